// File: rtl/irq_ctrl_if.sv
// IO-bus slave interface shared by the interrupt controller and its bus master.
// Carries the cs_/as_/rw strobes, register select, write data and registered response.
interface irq_ctrl_if;
    logic        cs_;
    logic        as_;
    logic        rw;
    logic [1:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rdy_;

    modport master (
        output cs_,
        output as_,
        output rw,
        output addr,
        output wr_data,
        input  rd_data,
        input  rdy_
    );

    modport slave (
        input  cs_,
        input  as_,
        input  rw,
        input  addr,
        input  wr_data,
        output rd_data,
        output rdy_
    );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending/mask registers, fixed-priority arbiter with ack/EOI handshake.
// Optional per-source edge mode (EDGE register at addr 3) is built when IRQ_CTRL_EDGE_EN is defined.
module irq_ctrl #(
    parameter int unsigned IRQ_NUM = 8
) (
    input  logic               clk,
    input  logic               reset,
    irq_ctrl_if.slave          bus,
    input  logic [IRQ_NUM-1:0] irq_in,
    output logic               cpu_irq,
    output logic [4:0]         cpu_irq_id,
    input  logic               cpu_ack
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 5;
    localparam int unsigned PAD_W  = DATA_W - ID_W - 1;

    localparam logic       RW_READ   = 1'b1;
    localparam logic [1:0] ADDR_PEND = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_STAT = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [IRQ_NUM-1:0]   pend_q, pend_d;
    logic [IRQ_NUM-1:0]   mask_q, mask_d;
    logic                 cpu_irq_q, cpu_irq_d;
    logic [ID_W-1:0]      cpu_irq_id_q, cpu_irq_id_d;
    logic [DATA_W-1:0]    rd_data_q, rd_data_d;
    logic                 rdy_q, rdy_d;

    logic                 acc;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 wr_pend;
    logic                 wr_mask;
    logic                 wr_stat;
    logic [IRQ_NUM-1:0]   wr_bits;
    logic [IRQ_NUM-1:0]   cap_set;
    logic [IRQ_NUM-1:0]   edge_rd;
    logic [IRQ_NUM-1:0]   req_vec;
    logic [ID_W-1:0]      low_idx;
    logic [IRQ_NUM-1:0]   id_onehot;
    logic                 id_live;
    logic [IRQ_NUM-1:0]   ack_clr;
    logic [IRQ_NUM-1:0]   w1c_clr;
    logic [DATA_W-1:0]    rd_mux;
    logic                 unused_wr_data;

    // Bus access decode: an access is any cycle with both strobes low.
    always_comb begin
        acc     = ~bus.cs_ & ~bus.as_;
        wr_acc  = acc & (bus.rw != RW_READ);
        rd_acc  = acc & (bus.rw == RW_READ);
        wr_pend = wr_acc & (bus.addr == ADDR_PEND);
        wr_mask = wr_acc & (bus.addr == ADDR_MASK);
        wr_stat = wr_acc & (bus.addr == ADDR_STAT);
        wr_bits = bus.wr_data[IRQ_NUM-1:0];
    end

    // Bits above IRQ_NUM are architecturally ignored on writes.
    assign unused_wr_data = ^bus.wr_data;

`ifdef IRQ_CTRL_EDGE_EN
    logic [IRQ_NUM-1:0] edge_q, edge_d;
    logic [IRQ_NUM-1:0] prev_q, prev_d;
    logic               wr_edge;

    always_comb begin
        wr_edge = wr_acc & (bus.addr == ADDR_EDGE);
        edge_d  = wr_edge ? wr_bits : edge_q;
        prev_d  = irq_in;
        cap_set = (irq_in & ~edge_q) | (irq_in & ~prev_q & edge_q);
        edge_rd = edge_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_q <= '0;
            prev_q <= '0;
        end else begin
            edge_q <= edge_d;
            prev_q <= prev_d;
        end
    end
`else
    assign cap_set = irq_in;
    assign edge_rd = '0;
`endif

    // Lowest enabled pending index wins.
    always_comb begin
        req_vec = pend_q & mask_q;
        low_idx = '0;
        for (int i = int'(IRQ_NUM) - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                low_idx = ID_W'(i);
            end
        end
    end

    // Decode the latched id into a source bit; avoids indexing with a wider id.
    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < int'(IRQ_NUM); i++) begin
            if (id_q == ID_W'(i)) begin
                id_onehot[i] = 1'b1;
            end
        end
        id_live = |(id_onehot & pend_q & mask_q);
    end

    // Arbiter next-state and registered CPU-side outputs.
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        ack_clr      = '0;
        cpu_irq_d    = 1'b0;
        cpu_irq_id_d = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (|req_vec) begin
                    id_d    = low_idx;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!id_live) begin
                    state_d = ST_IDLE;
                end else if (cpu_ack) begin
                    ack_clr = id_onehot;
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (wr_stat) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cpu_irq_d = (state_d == ST_REQ);
        if (state_d != ST_IDLE) begin
            cpu_irq_id_d = id_d;
        end
    end

    // Capture-set takes precedence over both software W1C and the ack clear.
    always_comb begin
        w1c_clr = wr_pend ? wr_bits : '0;
        pend_d  = (pend_q & ~(w1c_clr | ack_clr)) | cap_set;
        mask_d  = wr_mask ? wr_bits : mask_q;
    end

    // Register read mux and registered bus response.
    always_comb begin
        rd_mux = '0;
        unique case (bus.addr)
            ADDR_PEND: rd_mux = DATA_W'(pend_q);
            ADDR_MASK: rd_mux = DATA_W'(mask_q);
            ADDR_STAT: rd_mux = {PAD_W'(0), (state_q == ST_SERVICE), cpu_irq_id_q};
            ADDR_EDGE: rd_mux = DATA_W'(edge_rd);
            default:   rd_mux = '0;
        endcase
        rd_data_d = rd_acc ? rd_mux : '0;
        rdy_d     = ~acc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            id_q         <= '0;
            pend_q       <= '0;
            mask_q       <= '0;
            cpu_irq_q    <= 1'b0;
            cpu_irq_id_q <= '0;
            rd_data_q    <= '0;
            rdy_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            pend_q       <= pend_d;
            mask_q       <= mask_d;
            cpu_irq_q    <= cpu_irq_d;
            cpu_irq_id_q <= cpu_irq_id_d;
            rd_data_q    <= rd_data_d;
            rdy_q        <= rdy_d;
        end
    end

    assign cpu_irq     = cpu_irq_q;
    assign cpu_irq_id  = cpu_irq_id_q;
    assign bus.rd_data = rd_data_q;
    assign bus.rdy_    = rdy_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: directed scenarios followed by randomized traffic,
// all checked against a cycle-level behavioural model of the register/arbiter rules.
module tb_irq_ctrl;

    localparam int unsigned N = 8;
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;
`ifdef IRQ_CTRL_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq_in;
    logic         cpu_irq;
    logic [4:0]   cpu_irq_id;
    logic         cpu_ack;

    irq_ctrl_if bus_if ();

    irq_ctrl #(.IRQ_NUM(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_if),
        .irq_in     (irq_in),
        .cpu_irq    (cpu_irq),
        .cpu_irq_id (cpu_irq_id),
        .cpu_ack    (cpu_ack)
    );

    always #5 clk = ~clk;

    int          n_err = 0;
    int          n_chk = 0;
    int          n_rise = 0;
    bit          chk_en = 1'b0;
    logic        prev_irq = 1'b0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: state of the controller as the rules describe it.
    typedef enum int {M_IDLE, M_REQ, M_SVC} mstate_e;
    mstate_e      m_state, m_next;
    int           m_id;
    int           m_ack_id;
    bit [N-1:0]   m_pend, m_mask, m_edge, m_prev;
    bit           m_irq;
    bit [4:0]     m_irq_id;
    bit           m_rdy;
    bit           m_acc, m_wr, m_rd, m_set, m_clr;
    logic [31:0]  m_rv;

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            m_state  = M_IDLE;
            m_id     = 0;
            m_pend   = '0;
            m_mask   = '0;
            m_edge   = '0;
            m_prev   = '0;
            m_irq    = 1'b0;
            m_irq_id = '0;
            m_rdy    = 1'b1;
            sb_q.delete();
        end else if (reset === 1'b0) begin
            m_acc = (bus_if.cs_ === 1'b0) && (bus_if.as_ === 1'b0);
            m_wr  = m_acc && (bus_if.rw == RW_WRITE);
            m_rd  = m_acc && (bus_if.rw == RW_READ);
            case (bus_if.addr)
                2'd0:    m_rv = 32'(m_pend);
                2'd1:    m_rv = 32'(m_mask);
                2'd2:    m_rv = ((m_state == M_SVC) ? 32'd32 : 32'd0) + 32'(m_irq_id);
                default: m_rv = EDGE_EN ? 32'(m_edge) : 32'd0;
            endcase

            m_next   = m_state;
            m_ack_id = -1;
            case (m_state)
                M_IDLE: begin
                    for (int i = int'(N) - 1; i >= 0; i--) begin
                        if (m_pend[i] && m_mask[i]) begin
                            m_next = M_REQ;
                            m_id   = i;
                        end
                    end
                end
                M_REQ: begin
                    if (!(m_pend[m_id] && m_mask[m_id])) m_next = M_IDLE;
                    else if (cpu_ack) begin
                        m_next   = M_SVC;
                        m_ack_id = m_id;
                    end
                end
                default: if (m_wr && bus_if.addr == 2'd2) m_next = M_IDLE;
            endcase

            for (int i = 0; i < int'(N); i++) begin
                m_set = (EDGE_EN && m_edge[i]) ? (irq_in[i] && !m_prev[i]) : irq_in[i];
                m_clr = (m_wr && bus_if.addr == 2'd0 && bus_if.wr_data[i]) || (i == m_ack_id);
                if (m_set) m_pend[i] = 1'b1;
                else if (m_clr) m_pend[i] = 1'b0;
            end
            if (m_wr && bus_if.addr == 2'd1) m_mask = bus_if.wr_data[N-1:0];
            if (EDGE_EN && m_wr && bus_if.addr == 2'd3) m_edge = bus_if.wr_data[N-1:0];
            m_prev = irq_in;

            m_state  = m_next;
            m_irq    = (m_state == M_REQ);
            m_irq_id = (m_state == M_IDLE) ? 5'd0 : 5'(m_id);
            m_rdy    = !m_acc;
            if (m_acc) sb_q.push_back(m_rd ? m_rv : 32'd0);
        end
    end

    // Monitor: compares DUT outputs against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cpu_irq", 32'(cpu_irq), 32'(m_irq));
            check("cpu_irq_id", 32'(cpu_irq_id), 32'(m_irq_id));
            check("rdy_", 32'(bus_if.rdy_), 32'(m_rdy));
            if (bus_if.rdy_ === 1'b0) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL rd_resp: got rdy_ low with rd_data 0x%0h, required no response", bus_if.rd_data);
                end else begin
                    exp_v = sb_q.pop_front();
                    check("rd_data", bus_if.rd_data, exp_v);
                end
            end else begin
                check("rd_data_idle", bus_if.rd_data, 32'd0);
            end
            if (cpu_irq === 1'b1 && prev_irq !== 1'b1) n_rise++;
            prev_irq = cpu_irq;
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_if.cs_ = 1'b0; bus_if.as_ = 1'b0; bus_if.rw = RW_WRITE;
        bus_if.addr = a; bus_if.wr_data = d;
        @(negedge clk);
        bus_if.cs_ = 1'b1; bus_if.as_ = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
        bus_if.cs_ = 1'b0; bus_if.as_ = 1'b0; bus_if.rw = RW_READ;
        bus_if.addr = a; bus_if.wr_data = 32'd0;
        @(negedge clk);
        bus_if.cs_ = 1'b1; bus_if.as_ = 1'b1;
        v = bus_if.rd_data;
    endtask

    task automatic pulse_ack();
        cpu_ack = 1'b1;
        @(negedge clk);
        cpu_ack = 1'b0;
    endtask

    task automatic wait_irq(input int max_cyc);
        for (int k = 0; k < max_cyc && cpu_irq !== 1'b1; k++) @(negedge clk);
        check("wait_irq", 32'(cpu_irq), 32'd1);
    endtask

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout, required normal completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    logic [31:0] v;
    int          r, rise0;

    initial begin
        reset = 1'b1; cpu_ack = 1'b0; irq_in = '0;
        bus_if.cs_ = 1'b1; bus_if.as_ = 1'b1; bus_if.rw = RW_READ;
        bus_if.addr = 2'd0; bus_if.wr_data = 32'd0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_rd_data", bus_if.rd_data, 32'd0);
        check("rst_rdy", 32'(bus_if.rdy_), 32'd1);
        check("rst_cpu_irq", 32'(cpu_irq), 32'd0);
        reset = 1'b0;
        bus_read(2'd0, v); check("rst_pend", v, 32'd0);
        bus_read(2'd1, v); check("rst_mask", v, 32'd0);
        bus_read(2'd2, v); check("rst_stat", v, 32'd0);

        // Basic flow with two-cycle latency from a level pulse.
        bus_write(2'd1, 32'h01);
        irq_in[0] = 1'b1;
        @(negedge clk);
        irq_in[0] = 1'b0;
        check("lat_early", 32'(cpu_irq), 32'd0);
        @(negedge clk);
        check("lat_irq", 32'(cpu_irq), 32'd1);
        check("basic_id", 32'(cpu_irq_id), 32'd0);
        pulse_ack();
        check("ack_drop", 32'(cpu_irq), 32'd0);
        bus_read(2'd2, v); check("stat_svc", v, 32'h20);
        bus_write(2'd2, 32'd0);
        bus_read(2'd2, v); check("stat_eoi", v, 32'h00);

        // Priority between two simultaneous sources.
        bus_write(2'd1, 32'hFF);
        irq_in[5] = 1'b1; irq_in[2] = 1'b1;
        wait_irq(8);
        check("prio_id2", 32'(cpu_irq_id), 32'd2);
        irq_in[2] = 1'b0;
        pulse_ack();
        bus_write(2'd2, 32'd0);
        wait_irq(8);
        check("prio_id5", 32'(cpu_irq_id), 32'd5);
        irq_in[5] = 1'b0;
        pulse_ack();
        bus_write(2'd2, 32'd0);
        repeat (2) @(negedge clk);

        // Masked pending and write-1-to-clear.
        bus_write(2'd1, 32'h00);
        irq_in[3] = 1'b1;
        @(negedge clk);
        irq_in[3] = 1'b0;
        repeat (2) @(negedge clk);
        check("masked_irq", 32'(cpu_irq), 32'd0);
        bus_read(2'd0, v); check("masked_pend", v, 32'h08);
        bus_write(2'd0, 32'h08);
        bus_read(2'd0, v); check("w1c_pend", v, 32'h00);

        // Mask removal while requesting withdraws the request.
        bus_write(2'd1, 32'h08);
        irq_in[3] = 1'b1;
        @(negedge clk);
        irq_in[3] = 1'b0;
        wait_irq(8);
        check("mask_req_id", 32'(cpu_irq_id), 32'd3);
        bus_write(2'd1, 32'h00);
        @(negedge clk);
        check("mask_withdraw", 32'(cpu_irq), 32'd0);
        bus_read(2'd0, v); check("mask_pend_kept", v, 32'h08);
        bus_write(2'd0, 32'h08);

        // Level source held through ack: capture wins over the ack clear.
        bus_write(2'd1, 32'h02);
        irq_in[1] = 1'b1;
        wait_irq(8);
        check("simul_id", 32'(cpu_irq_id), 32'd1);
        pulse_ack();
        bus_read(2'd0, v); check("simul_pend", v, 32'h02);
        bus_read(2'd2, v); check("simul_stat", v, 32'h21);
        bus_write(2'd2, 32'd0);
        wait_irq(4);
        check("simul_reirq_id", 32'(cpu_irq_id), 32'd1);
        irq_in[1] = 1'b0;
        pulse_ack();
        bus_write(2'd2, 32'd0);
        bus_write(2'd1, 32'h00);
        bus_read(2'd0, v); check("simul_pend_clr", v, 32'h00);

`ifdef IRQ_CTRL_EDGE_EN
        // Edge source held high yields a single request.
        bus_write(2'd3, 32'h10);
        bus_write(2'd1, 32'h10);
        rise0 = n_rise;
        irq_in[4] = 1'b1;
        wait_irq(4);
        check("edge_id", 32'(cpu_irq_id), 32'd4);
        pulse_ack();
        bus_write(2'd2, 32'd0);
        repeat (6) @(negedge clk);
        check("edge_one_req", 32'(n_rise - rise0), 32'd1);
        bus_read(2'd0, v); check("edge_pend", v, 32'h00);
        irq_in[4] = 1'b0;
        bus_read(2'd3, v); check("edge_reg", v, 32'h10);
        bus_write(2'd3, 32'h00);
        bus_write(2'd1, 32'h00);
`else
        bus_write(2'd3, 32'hFF);
        bus_read(2'd3, v); check("edge_absent", v, 32'h00);
`endif

        // Reset while in service abandons the interrupt.
        bus_write(2'd1, 32'h01);
        irq_in[0] = 1'b1;
        wait_irq(8);
        pulse_ack();
        bus_read(2'd2, v); check("rst_svc_stat", v, 32'h20);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_abandon_irq", 32'(cpu_irq), 32'd0);
        bus_read(2'd2, v); check("rst_abandon_stat", v, 32'h00);
        bus_read(2'd1, v); check("rst_abandon_mask", v, 32'h00);
        irq_in[0] = 1'b0;
        bus_write(2'd0, 32'hFF);

        // Randomized traffic checked entirely by the model.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) irq_in = N'($urandom);
            cpu_ack = (cpu_irq === 1'b1) && ($urandom_range(0, 2) == 0);
            r = int'($urandom_range(0, 5));
            bus_if.cs_ = 1'b1; bus_if.as_ = 1'b1;
            if (r < 2) begin
                bus_if.cs_ = 1'b0; bus_if.as_ = 1'b0;
                bus_if.rw = $urandom_range(0, 1) == 1 ? RW_READ : RW_WRITE;
                bus_if.addr = 2'($urandom_range(0, 3));
                bus_if.wr_data = $urandom;
            end else if (r == 2) begin
                bus_if.cs_ = 1'b0;
            end
            @(negedge clk);
        end
        bus_if.cs_ = 1'b1; bus_if.as_ = 1'b1; cpu_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
